// File: rtl/pb_poll_pkg.sv
// pb_poll_pkg: shared types and helpers for the pushbutton poll master.
// Holds the poll FSM state encoding and the {rise, fall} event layout.
package pb_poll_pkg;

    // Poll sequencer states: wait for a tick, issue the read, wait out the
    // slave latency, then run one debounce/event evaluation cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        EVAL = 2'd3
    } pb_fsm_e;

    // Default button count and the matching event word width.
    localparam int PB_W_DEF = 4;
    localparam int PB_EVT_W = 2 * PB_W_DEF;

    // Event word layout for the default width: rise mask in the upper half,
    // fall mask in the lower half.
    typedef struct packed {
        logic [PB_W_DEF-1:0] rise;
        logic [PB_W_DEF-1:0] fall;
    } pb_event_t;

    // Event word width for an arbitrary button count.
    function automatic int evt_width(input int pb_w);
        return 2 * pb_w;
    endfunction

endpackage

// File: rtl/pb_event_fifo.sv
// pb_event_fifo: synchronous show-ahead FIFO for button events.
// Head entry is visible on data_o whenever empty_o is low. A push while full
// is accepted only if a pop happens on the same cycle.
module pb_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Control registers: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while their slot is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pb_poll_master.sv
// pb_poll_master: Avalon-MM read initiator that periodically polls the
// pushbutton PIO, filters the sampled levels and queues press/release events.
// Build option: define PB_DEBOUNCE_EN to require DEBOUNCE_SAMPLES consecutive
// equal samples before a level change is accepted; without it every changed
// sample is accepted in the evaluation cycle and no counter is built.
module pb_poll_master
    import pb_poll_pkg::*;
#(
    parameter int              PB_W             = 4,
    parameter int              POLL_DIV         = 50000,
    parameter int              READ_LATENCY     = 1,
    parameter int              DEBOUNCE_SAMPLES = 4,
    parameter int              FIFO_DEPTH       = 8,
    parameter logic [PB_W-1:0] PB_RESET_VAL     = {PB_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic [1:0]                 avm_address,
    output logic                       avm_read,
    input  logic                       avm_waitrequest,
    input  logic [31:0]                avm_readdata,
    output logic [PB_W-1:0]            pb_state,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [evt_width(PB_W)-1:0] evt_data,
    output logic                       evt_overflow
);

    localparam int EW    = evt_width(PB_W);
    localparam int TMR_W = $clog2(POLL_DIV);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);

    pb_fsm_e           state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              tick_pend_q, tick_pend_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [PB_W-1:0]   sample_q;
    logic [PB_W-1:0]   pb_state_q, pb_state_d;
    logic              ovf_q, ovf_d;
    logic              tick;
    logic              rd_start;
    logic              capture;
    logic              push;
    logic [PB_W-1:0]   evt_rise, evt_fall;
    logic [EW-1:0]     fifo_din;
    logic              fifo_full, fifo_empty;
    logic [31-PB_W:0]  readdata_hi_unused;

    // Only the low PB_W bits of the PIO word carry button levels.
    assign readdata_hi_unused = avm_readdata[31:PB_W];

`ifdef PB_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);

    logic [PB_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Without filtering the sample count threshold has no role.
    localparam int DEB_SAMPLES_UNUSED = DEBOUNCE_SAMPLES;
`endif

    assign tick     = (timer_q == '0);
    assign rd_start = (state_q == IDLE) && tick_pend_q;
    assign capture  = (state_q == LAT) && (lat_q == '0);

    // Poll timer, pending-tick flag and latency counter next-state.
    always_comb begin
        timer_d = tick ? TMR_RELOAD : (timer_q - TMR_W'(1));

        // A new enabled tick wins over the clear so it is never lost.
        tick_pend_d = tick_pend_q;
        if (tick && enable) begin
            tick_pend_d = 1'b1;
        end else if (rd_start) begin
            tick_pend_d = 1'b0;
        end

        lat_d = lat_q;
        if (state_q == REQ) begin
            lat_d = LAT_RELOAD;
        end else if (state_q == LAT && lat_q != '0) begin
            lat_d = lat_q - LAT_W'(1);
        end
    end

    // FSM next-state: one read per pending tick, stalled by waitrequest.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_pend_q)      state_d = REQ;
            REQ:     if (!avm_waitrequest) state_d = LAT;
            LAT:     if (lat_q == '0)      state_d = EVAL;
            EVAL:                          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // FSM outputs: the read strobe is asserted for the whole REQ state.
    always_comb begin
        avm_read    = (state_q == REQ);
        avm_address = 2'd0;
    end

    // Level filter and event generation, active only in the EVAL cycle.
    always_comb begin
        pb_state_d = pb_state_q;
        push       = 1'b0;
`ifdef PB_DEBOUNCE_EN
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (state_q == EVAL) begin
            if (sample_q == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cand_d = sample_q;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX && cand_d != pb_state_q) begin
                push       = 1'b1;
                pb_state_d = cand_d;
            end
        end
`else
        if (state_q == EVAL && sample_q != pb_state_q) begin
            push       = 1'b1;
            pb_state_d = sample_q;
        end
`endif
        evt_rise = pb_state_d & ~pb_state_q;
        evt_fall = ~pb_state_d & pb_state_q;
    end

    assign fifo_din = {evt_rise, evt_fall};

    // Overflow is sticky: set when an event finds the FIFO full with no pop.
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !evt_ready) begin
            ovf_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= TMR_RELOAD;
            tick_pend_q <= 1'b0;
            lat_q       <= '0;
            pb_state_q  <= PB_RESET_VAL;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tick_pend_q <= tick_pend_d;
            lat_q       <= lat_d;
            pb_state_q  <= pb_state_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef PB_DEBOUNCE_EN
    // Debounce candidate and run-length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= PB_RESET_VAL;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    // Sample register: takes the read data on the last latency cycle.
    always_ff @(posedge clk) begin
        if (capture) begin
            sample_q <= avm_readdata[PB_W-1:0];
        end
    end

    pb_event_fifo #(
        .DATA_W (EW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (fifo_din),
        .pop_i   (evt_ready),
        .data_o  (evt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pb_state     = pb_state_q;
    assign evt_valid    = !fifo_empty;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_pb_poll_master.sv
// tb_pb_poll_master: directed bench for pb_poll_master with a small poll
// period and a registered, one-cycle-latency PIO slave model.
`timescale 1ns/1ps
module tb_pb_poll_master;

    localparam int PB_W     = 4;
    localparam int POLL_DIV = 8;
    localparam int RD_LAT   = 1;
    localparam int DEB      = 4;
    localparam int DEPTH    = 8;
`ifdef PB_DEBOUNCE_EN
    localparam int NEED = DEB;
`else
    localparam int NEED = 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [1:0]      avm_address;
    logic            avm_read;
    logic            avm_waitrequest;
    logic [31:0]     avm_readdata;
    logic [PB_W-1:0] pb_state;
    logic            evt_valid;
    logic            evt_ready;
    logic [7:0]      evt_data;
    logic            evt_overflow;
    logic [PB_W-1:0] pb_in;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pb_poll_master #(
        .PB_W             (PB_W),
        .POLL_DIV         (POLL_DIV),
        .READ_LATENCY     (RD_LAT),
        .DEBOUNCE_SAMPLES (DEB),
        .FIFO_DEPTH       (DEPTH),
        .PB_RESET_VAL     (4'hF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .pb_state        (pb_state),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_data        (evt_data),
        .evt_overflow    (evt_overflow)
    );

    // PIO slave: readdata registered on the accepting edge.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= {28'h0, pb_in};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the read strobe, then check the address.
    task automatic wait_read(output int n);
        n = 0;
        while (avm_read !== 1'b1 && n < 4 * POLL_DIV) begin
            @(negedge clk);
            n++;
        end
        check("read_strobe", 32'(avm_read), 32'h1);
        check("read_addr", 32'(avm_address), 32'h0);
    endtask

    // One complete poll with the buttons at v; returns in IDLE after EVAL.
    task automatic poll(input logic [3:0] v, output int n);
        pb_in = v;
        wait_read(n);
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(evt_valid), 32'h1);
        check({tag, "_data"}, 32'(evt_data), 32'(exp));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int reads;
        logic [7:0] t3_exp [6];
        logic [3:0] t3_val [6];

        t3_val = '{4'hE, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE};
`ifdef PB_DEBOUNCE_EN
        t3_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
        t3_exp = '{8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00};
`endif

        reset           = 1'b1;
        enable          = 1'b0;
        avm_waitrequest = 1'b0;
        evt_ready       = 1'b0;
        pb_in           = 4'hF;
        avm_readdata    = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_read", 32'(avm_read), 32'h0);
        check("rst_addr", 32'(avm_address), 32'h0);
        check("rst_pb_state", 32'(pb_state), 32'hF);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_overflow", 32'(evt_overflow), 32'h0);
        reset = 1'b0;

        // 1: steady released buttons, reads every POLL_DIV cycles
        enable = 1'b1;
        poll(4'hF, n);
        poll(4'hF, n);
        check("t1_interval_a", 32'(n + 3), 32'(POLL_DIV));
        poll(4'hF, n);
        check("t1_interval_b", 32'(n + 3), 32'(POLL_DIV));
        check("t1_pb_state", 32'(pb_state), 32'hF);
        check("t1_no_event", 32'(evt_valid), 32'h0);

        // Ticks with enable low start no reads
        enable = 1'b0;
        reads = 0;
        for (int i = 0; i < 3 * POLL_DIV; i++) begin
            @(negedge clk);
            if (avm_read === 1'b1) reads++;
        end
        check("dis_no_reads", 32'(reads), 32'h0);
        enable = 1'b1;

        // 2: button 0 pressed and held
        for (int i = 0; i < NEED - 1; i++) begin
            poll(4'hE, n);
            check("t2_no_event_yet", 32'(evt_valid), 32'h0);
        end
        poll(4'hE, n);
        check("t2_pb_state", 32'(pb_state), 32'hE);
        pop_check("t2_evt", 8'h01);
        check("t2_empty", 32'(evt_valid), 32'h0);

        // 3: bouncing contact
        do_reset();
        for (int i = 0; i < 6; i++) begin
            poll(t3_val[i], n);
            if (t3_exp[i] != 8'h00) pop_check("t3_evt", t3_exp[i]);
            else check("t3_no_event", 32'(evt_valid), 32'h0);
        end
        check("t3_pb_state", 32'(pb_state), 32'hE);

        // 4: stalled read; sample reflects data at acceptance
        pb_in = 4'hE;
        avm_waitrequest = 1'b1;
        wait_read(n);
        pb_in = 4'hF;
        for (int i = 0; i < 10; i++) begin
            check("t4_read_held", 32'(avm_read), 32'h1);
            check("t4_addr_held", 32'(avm_address), 32'h0);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NEED - 1; i++) poll(4'hF, n);
        check("t4_pb_state", 32'(pb_state), 32'hF);
        pop_check("t4_evt", 8'h10);

        // 5: nine changes with no consumer; ninth is dropped
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < NEED; k++) poll((i % 2 == 0) ? 4'hE : 4'hF, n);
            if (i == 7) check("t5_no_ovf_at_8", 32'(evt_overflow), 32'h0);
        end
        check("t5_overflow", 32'(evt_overflow), 32'h1);
        check("t5_pb_state", 32'(pb_state), 32'hE);
        for (int i = 0; i < 8; i++) begin
            pop_check("t5_pop", (i % 2 == 0) ? 8'h01 : 8'h10);
        end
        check("t5_drained", 32'(evt_valid), 32'h0);

        // 6: reset during the latency phase of a read
        for (int k = 0; k < NEED; k++) poll(4'hF, n);
        for (int k = 0; k < NEED; k++) poll(4'hE, n);
        check("t6_pre_pb_state", 32'(pb_state), 32'hE);
        check("t6_pre_valid", 32'(evt_valid), 32'h1);
        wait_read(n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_read_low", 32'(avm_read), 32'h0);
        check("t6_fifo_empty", 32'(evt_valid), 32'h0);
        check("t6_ovf_clear", 32'(evt_overflow), 32'h0);
        check("t6_pb_state", 32'(pb_state), 32'hF);
        reset = 1'b0;
        for (int k = 0; k < NEED; k++) poll(4'hE, n);
        check("t6_resume_pb_state", 32'(pb_state), 32'hE);
        pop_check("t6_resume_evt", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
